// File: rtl/ysyx_23060096_imem_responder.sv
// Instruction-memory responder: valid/ready fetch port, fixed LATENCY, fault flagging, preload port.
// Optional YSYX_23060096_IMEM_ERR_EBREAK_EN: faulted fetches return ebreak instead of zero.
module ysyx_23060096_imem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef YSYX_23060096_IMEM_ERR_EBREAK_EN
    localparam logic [31:0] FAULT_INST = 32'h0010_0073;
`else
    localparam logic [31:0] FAULT_INST = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        addr_reg;
    logic               resp_err_reg;
    logic               data_ok_reg;
    logic [31:0]        rd_data_reg;
    logic               accept;
    logic               load_resp;

    logic [31:0]        mem [DEPTH];

    // Offsets wrap, so addresses below BASE_ADDR land far out of range.
    function automatic logic addr_ok(input logic [31:0] off);
        return (off[1:0] == 2'b00) && ((off >> (IDX_W + 2)) == 32'd0);
    endfunction

    logic [31:0]        rd_addr;
    logic [31:0]        rd_off;
    logic               rd_fault;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        prog_off;
    logic               prog_ok;
    logic [IDX_W-1:0]   prog_idx;

    // With LATENCY==1 the read happens on the accept edge, before addr_reg holds the pc.
    assign rd_addr  = (state_reg == IDLE) ? req_addr : addr_reg;
    assign rd_off   = rd_addr - BASE_ADDR;
    assign rd_fault = !addr_ok(rd_off);
    assign rd_idx   = rd_off[IDX_W+1:2];

    assign prog_off = prog_addr - BASE_ADDR;
    assign prog_ok  = prog_we && addr_ok(prog_off);
    assign prog_idx = prog_off[IDX_W+1:2];

    assign req_ready  = rstn && (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_err   = resp_err_reg;
    assign resp_inst  = data_ok_reg  ? rd_data_reg :
                        resp_err_reg ? FAULT_INST  : 32'h0000_0000;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        load_resp  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    cnt_next = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        load_resp  = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= 32'h0000_0000;
            resp_err_reg <= 1'b0;
            data_ok_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= req_addr;
            end
            if (load_resp) begin
                resp_err_reg <= rd_fault;
                data_ok_reg  <= !rd_fault;
            end
        end
    end

    // Array kept out of reset so it maps to block RAM; NBA gives read-old-data on collisions.
    always_ff @(posedge clk) begin
        if (prog_ok) begin
            mem[prog_idx] <= prog_data;
        end
        if (load_resp && !rd_fault) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_imem_responder.sv
// Directed bench: four responders with LATENCY 1..4 sharing one preload port and reset.
module tb_ysyx_23060096_imem_responder;

`ifdef YSYX_23060096_IMEM_ERR_EBREAK_EN
    localparam logic [31:0] FI = 32'h0010_0073;
`else
    localparam logic [31:0] FI = 32'h0000_0000;
`endif

    logic        clk;
    logic        rstn;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    logic        req_valid  [4];
    logic        req_ready  [4];
    logic [31:0] req_addr   [4];
    logic        resp_valid [4];
    logic        resp_ready [4];
    logic [31:0] resp_inst  [4];
    logic        resp_err   [4];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        ysyx_23060096_imem_responder #(
            .BASE_ADDR (32'h8000_0000),
            .DEPTH     (1024),
            .LATENCY   (gi + 1)
        ) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .req_valid  (req_valid[gi]),
            .req_ready  (req_ready[gi]),
            .req_addr   (req_addr[gi]),
            .resp_valid (resp_valid[gi]),
            .resp_ready (resp_ready[gi]),
            .resp_inst  (resp_inst[gi]),
            .resp_err   (resp_err[gi]),
            .prog_we    (prog_we),
            .prog_addr  (prog_addr),
            .prog_data  (prog_data)
        );
    end

    typedef struct {
        int          k;
        logic [31:0] addr;
        int          stall;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [11];
    logic [31:0] stream_exp [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    // Instance k has LATENCY k+1.
    task automatic fetch(input int k, input logic [31:0] addr, input int stall,
                         input logic [31:0] exp_inst, input logic exp_err);
        int lat;
        @(posedge clk); #1;
        req_valid[k] = 1'b1; req_addr[k] = addr; resp_ready[k] = (stall == 0);
        @(negedge clk);
        chk("req_ready_idle", req_ready[k], 1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0; req_addr[k] = 32'hFFFF_FFFF;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid[k]) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            chk("resp_timeout", resp_valid[k], 1);
            resp_ready[k] = 1'b0;
            return;
        end
        chk("latency", lat, k + 1);
        chk("resp_inst", resp_inst[k], exp_inst);
        chk("resp_err", resp_err[k], exp_err);
        $display("fetch k=%0d addr=%h lat=%0d inst=%h err=%0d", k, addr, lat, resp_inst[k], resp_err[k]);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            chk("stall_valid", resp_valid[k], 1);
            chk("stall_inst", resp_inst[k], exp_inst);
            chk("stall_ready", req_ready[k], 0);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            resp_ready[k] = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        @(negedge clk);
        chk("valid_cleared", resp_valid[k], 0);
        chk("ready_back", req_ready[k], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{0, 32'h8000_0000, 0, 32'h0010_0093, 1'b0};
        vecs[1]  = '{0, 32'h8000_0002, 0, FI,            1'b1};
        vecs[2]  = '{0, 32'h7FFF_FFFC, 0, FI,            1'b1};
        vecs[3]  = '{0, 32'h8000_1000, 0, FI,            1'b1};
        vecs[4]  = '{0, 32'h8000_0FFC, 0, 32'hCAFE_F00D, 1'b0};
        vecs[5]  = '{0, 32'h8000_0008, 0, 32'h1234_5678, 1'b0};
        vecs[6]  = '{0, 32'h0000_0000, 0, FI,            1'b1};
        vecs[7]  = '{3, 32'h8000_0004, 5, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1, 32'h8000_000C, 1, 32'h0000_0513, 1'b0};
        vecs[9]  = '{2, 32'h8000_0FFC, 0, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{2, 32'h8000_0002, 2, FI,            1'b1};
        stream_exp = '{32'h0010_0093, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0513,
                       32'h1111_1111, 32'hA5A5_0005, 32'hA5A5_0006, 32'hA5A5_0007};

        rstn = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_req_ready", req_ready[i], 0);
            chk("rst_resp_valid", resp_valid[i], 0);
            chk("rst_resp_inst", resp_inst[i], 0);
            chk("rst_resp_err", resp_err[i], 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready[0], 1);

        // Preload, including writes that must be dropped
        @(posedge clk); #1;
        prog(32'h8000_0000, 32'h0010_0093);
        prog(32'h8000_0004, 32'hDEAD_BEEF);
        prog(32'h8000_0008, 32'h1234_5678);
        prog(32'h8000_000C, 32'h0000_0513);
        prog(32'h8000_0010, 32'h2222_2222);
        prog(32'h8000_0014, 32'hA5A5_0005);
        prog(32'h8000_0018, 32'hA5A5_0006);
        prog(32'h8000_001C, 32'hA5A5_0007);
        prog(32'h8000_0FFC, 32'hCAFE_F00D);
        prog(32'h8000_1000, 32'hBAD0_0000);
        prog(32'h8000_0009, 32'hBAD1_1111);
        prog(32'h7FFF_FFFC, 32'hBAD2_2222);

        for (int v = 0; v < 11; v++) begin
            fetch(vecs[v].k, vecs[v].addr, vecs[v].stall, vecs[v].inst, vecs[v].err);
        end

        // Collision on LATENCY=2: write lands on the RESP-entry edge
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_addr[1] = 32'h8000_0010; resp_ready[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        prog_we = 1'b1; prog_addr = 32'h8000_0010; prog_data = 32'h1111_1111;
        @(posedge clk); #1;
        prog_we = 1'b0;
        @(negedge clk);
        chk("coll_valid", resp_valid[1], 1);
        chk("coll_old_word", resp_inst[1], 32'h2222_2222);
        $display("collision inst=%h", resp_inst[1]);
        resp_ready[1] = 1'b1;
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        fetch(1, 32'h8000_0010, 0, 32'h1111_1111, 1'b0);

        // Reset mid-WAIT (LATENCY=3) and mid-RESP (LATENCY=1)
        @(posedge clk); #1;
        req_valid[2] = 1'b1; req_addr[2] = 32'h8000_0000; resp_ready[2] = 1'b1;
        req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0004; resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[2] = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_resp0", resp_valid[0], 1);
        chk("pre_rst_inst0", resp_inst[0], 32'hDEAD_BEEF);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_wait_valid", resp_valid[2], 0);
        chk("rst_wait_ready", req_ready[2], 0);
        chk("rst_resp_drop", resp_valid[0], 0);
        chk("rst_inst_clear", resp_inst[0], 0);
        $display("mid-op reset applied valid0=%0d valid2=%0d", resp_valid[0], resp_valid[2]);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_rel_ready", req_ready[2], 1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid[2] || resp_valid[0]) seen++;
        end
        chk("no_ghost_resp", seen, 0);
        resp_ready[2] = 1'b0;

        // Back-to-back stream on LATENCY=1, one accept every two cycles
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_addr[0] = 32'h8000_0000; resp_ready[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stream_ready", req_ready[0], 1);
            @(posedge clk); #1;
            req_addr[0] = 32'h8000_0000 + 32'(4 * (k + 1));
            if (k == 7) req_valid[0] = 1'b0;
            @(negedge clk);
            chk("stream_valid", resp_valid[0], 1);
            chk("stream_inst", resp_inst[0], stream_exp[k]);
            $display("stream k=%0d inst=%h", k, resp_inst[0]);
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b0;
        @(negedge clk);
        chk("stream_idle", resp_valid[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_imem_responder.md
Name: ysyx_23060096_imem_responder

Overview:
- Instruction-memory responder: the memory end of the core's fetch interface, which issues a pc and consumes a 32-bit instruction.
- Accepts one fetch request per valid/ready handshake and returns the addressed word after a fixed programmable latency.
- Flags misaligned and out-of-range fetches.
- A side write port preloads the array; bench or boot loader only.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 2.
- LATENCY, 1, cycles from request accept to resp_valid; ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address (pc).
- resp_valid  out  1  response valid.
- resp_ready  in  1  core consumes response.
- resp_inst  out  32  fetched instruction.
- resp_err  out  1  fetch fault (misaligned or out of range).
- prog_we  in  1  preload write enable.
- prog_addr  in  32  preload byte address, same map as req_addr.
- prog_data  in  32  preload word.

Behaviour:
- One clock, clk. rstn is asynchronous, active-low.
- Reset values:
  - state=IDLE, req_ready=0 while rstn=0, resp_valid=0, resp_inst=0, resp_err=0, latency counter=0.
  - Memory array is not reset.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counting.
  - RESP: resp_valid=1.
- IDLE: on req_valid&&req_ready, latch req_addr and load counter=LATENCY-1.
  - LATENCY==1: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement the counter each cycle; when the counter is 1, go to RESP next edge.
- Latency: resp_valid rises exactly LATENCY cycles after the accepting edge.
- Array read and fault check happen on the edge entering RESP; resp_inst and resp_err are registered there.
- RESP:
  - resp_valid, resp_inst and resp_err are held stable until resp_valid&&resp_ready.
  - On that handshake edge, go to IDLE and clear resp_valid.
  - req_ready is 0 in WAIT and RESP, so there is no same-cycle response-and-accept.
  - Maximum throughput is one fetch per LATENCY+1 cycles.
- Address map:
  - off = req_addr - BASE_ADDR, 32-bit unsigned, wraps.
  - Misaligned fault: off[1:0] != 0.
  - Range fault: off >= DEPTH*4. Addresses below BASE_ADDR wrap to a large value and fault.
  - On any fault: resp_err=1 and resp_inst=32'h0000_0000; the array is not read. Otherwise index = off[log2(DEPTH)+1:2].
- Preload:
  - prog_we writes prog_data at the index of prog_addr on the clock edge, in any state.
  - Misaligned or out-of-range preload writes are silently dropped.
  - A preload write on the same edge as the array read to the same index: the read returns the old word.
  - Later fetches see the new word.
- req_addr, req_valid and resp_ready are ignored outside the states that use them.
- Reset mid-operation: the pending request is discarded, resp_valid drops asynchronously, and the FSM returns to IDLE; array contents are preserved.

Optional Feature:
- Macro: YSYX_23060096_IMEM_ERR_EBREAK_EN.
- Defined: on a fault, resp_inst=32'h0010_0073 (ebreak), so the core halts through its existing ebreak path; resp_err is still 1.
- Not defined: on a fault, resp_inst=32'h0000_0000.

Test Plan:
- Reset check: assert rstn=0 mid-WAIT with LATENCY=3 → resp_valid=0 immediately; after release, req_ready=1 and no response ever appears for the dropped request.
- Basic fetch: preload 0x8000_0000←0x0010_0093, LATENCY=1; request 0x8000_0000 with resp_ready=1 → resp_valid one cycle after accept, resp_inst=0x0010_0093, resp_err=0, req_ready back to 1 the cycle after the handshake.
- Latency and backpressure: LATENCY=4, preload 0x8000_0004←0xDEAD_BEEF; request 0x8000_0004, hold resp_ready=0 for 5 cycles → resp_valid exactly 4 cycles after accept; output stays 0xDEAD_BEEF through the stall; req_ready=0 until the handshake.
- Faults: request 0x8000_0002 → resp_err=1, resp_inst=0 (0x0010_0073 with the macro). Request 0x7FFF_FFFC → resp_err=1. Request BASE_ADDR+DEPTH*4 → resp_err=1. Request BASE_ADDR+DEPTH*4-4 → resp_err=0.
- Write/read collision: LATENCY=2, prog_we to the fetched index on the RESP-entry edge with 0x1111_1111 over old 0x2222_2222 → resp_inst=0x2222_2222; the next fetch of the same address returns 0x1111_1111.
- Back-to-back stream: 8 consecutive requests at 0x8000_0000+4k, resp_ready=1, LATENCY=1 → accepts every 2 cycles and responses arrive in order with the preloaded values.
